// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and thickness defaults for the display config controller
package vga_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_DEB_PRESS,
    BTN_HELD,
    BTN_DEB_REL
  } btn_state_e;

  localparam int VGA_THICK_MIN = 1;
  localparam int VGA_THICK_MAX = 8;
  localparam int VGA_THICK_RST = 2;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronised, debounced active-low pushbutton with one-shot press event
module btn_debounce
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_press,
  output logic o_busy
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    r_sync;
  btn_state_e    r_state;
  btn_state_e    w_next_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_lvl;

  assign w_lvl = r_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_state <= BTN_IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_btn_n};
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Counter tops out at DEBOUNCE_CYC-1 and the FSM leaves the state there, so it cannot wrap.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    o_press      = 1'b0;
    case (r_state)
      BTN_IDLE: begin
        w_cnt_next = '0;
        if (!w_lvl) w_next_state = BTN_DEB_PRESS;
      end
      BTN_DEB_PRESS: begin
        if (w_lvl) begin
          w_next_state = BTN_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = BTN_HELD;
          o_press      = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      BTN_HELD: begin
        w_cnt_next = '0;
        if (w_lvl) w_next_state = BTN_DEB_REL;
      end
      BTN_DEB_REL: begin
        if (!w_lvl) begin
          w_next_state = BTN_HELD;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = BTN_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_next_state = BTN_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_busy = (r_state == BTN_DEB_PRESS) || (r_state == BTN_DEB_REL);

endmodule

// File: rtl/vga_disp_cfg_ctrl.sv
// rtl/vga_disp_cfg_ctrl.sv - button-driven wave display config, committed once per frame
module vga_disp_cfg_ctrl
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int THICK_MIN    = VGA_THICK_MIN,
  parameter int THICK_MAX    = VGA_THICK_MAX,
  parameter int THICK_RST    = VGA_THICK_RST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       show_cl,
  input  logic       plus_thick,
  input  logic       minus_thick,
  input  logic       frame_start,
  output logic       cfg_show_cl,
  output logic [3:0] cfg_thick,
  output logic       cfg_upd,
  output logic       busy
);

  localparam logic [3:0] TMIN = 4'(THICK_MIN);
  localparam logic [3:0] TMAX = 4'(THICK_MAX);
  localparam logic [3:0] TRST = 4'(THICK_RST);

  logic       w_show_press, w_plus_press, w_minus_press;
  logic [2:0] w_deb_busy;
  logic       r_pend_show, r_cfg_show;
  logic [3:0] r_pend_thick, r_cfg_thick;
  logic [3:0] w_pend_thick_next;
  logic       r_fs_d;
  logic       w_changed;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_show (
    .clk(clk), .rst(rst), .i_btn_n(show_cl), .o_press(w_show_press), .o_busy(w_deb_busy[0])
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_plus (
    .clk(clk), .rst(rst), .i_btn_n(plus_thick), .o_press(w_plus_press), .o_busy(w_deb_busy[1])
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_minus (
    .clk(clk), .rst(rst), .i_btn_n(minus_thick), .o_press(w_minus_press), .o_busy(w_deb_busy[2])
  );

  always_comb begin
    w_pend_thick_next = r_pend_thick;
    if (w_plus_press && !w_minus_press && (r_pend_thick < TMAX))
      w_pend_thick_next = r_pend_thick + 4'd1;
    else if (w_minus_press && !w_plus_press && (r_pend_thick > TMIN))
      w_pend_thick_next = r_pend_thick - 4'd1;
  end

  // Commit one cycle after frame_start so a press landing on frame_start is included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_show  <= 1'b1;
      r_pend_thick <= TRST;
      r_cfg_show   <= 1'b1;
      r_cfg_thick  <= TRST;
      r_fs_d       <= 1'b0;
    end else begin
      r_pend_show  <= r_pend_show ^ w_show_press;
      r_pend_thick <= w_pend_thick_next;
      r_fs_d       <= frame_start;
      if (r_fs_d) begin
        r_cfg_show  <= r_pend_show;
        r_cfg_thick <= r_pend_thick;
      end
    end
  end

  assign w_changed   = (r_pend_show != r_cfg_show) || (r_pend_thick != r_cfg_thick);
  assign cfg_show_cl = r_cfg_show;
  assign cfg_thick   = r_cfg_thick;
  assign cfg_upd     = r_fs_d && w_changed;
  assign busy        = (|w_deb_busy) || w_changed;

endmodule

// File: tb/tb_vga_disp_cfg_ctrl.sv
// tb/tb_vga_disp_cfg_ctrl.sv - directed vector bench for vga_disp_cfg_ctrl
module tb_vga_disp_cfg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       show_cl = 1'b1;
  logic       plus_thick = 1'b1;
  logic       minus_thick = 1'b1;
  logic       frame_start = 1'b0;
  logic       cfg_show_cl;
  logic [3:0] cfg_thick;
  logic       cfg_upd;
  logic       busy;

  int n_cmp = 0;
  int n_fail = 0;

  vga_disp_cfg_ctrl #(.DEBOUNCE_CYC(4)) dut (
    .clk(clk), .rst(rst), .show_cl(show_cl), .plus_thick(plus_thick),
    .minus_thick(minus_thick), .frame_start(frame_start), .cfg_show_cl(cfg_show_cl),
    .cfg_thick(cfg_thick), .cfg_upd(cfg_upd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n_plus;
    int n_minus;
    int n_show;
    bit simul;
    int exp_thick;
    int exp_show;
    int exp_upd;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    show_cl = 1'b1; plus_thick = 1'b1; minus_thick = 1'b1; frame_start = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic press(input bit p, input bit m, input bit s);
    plus_thick = !p; minus_thick = !m; show_cl = !s;
    repeat (8) tick();
    plus_thick = 1'b1; minus_thick = 1'b1; show_cl = 1'b1;
    repeat (10) tick();
  endtask

  // Returns cfg_upd seen in the commit cycle and the number of pulses in the following three.
  task automatic frame(output logic upd, output int extra);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    upd = cfg_upd;
    tick();
    extra = 0;
    repeat (3) begin
      extra += int'(cfg_upd);
      tick();
    end
  endtask

  logic u;
  int   e;

  initial begin
    vecs[0] = '{1, 0, 0, 1'b0, 3, 1, 1};
    vecs[1] = '{8, 0, 0, 1'b0, 8, 1, 1};
    vecs[2] = '{0, 1, 0, 1'b0, 1, 1, 1};
    vecs[3] = '{0, 3, 0, 1'b0, 1, 1, 1};
    vecs[4] = '{0, 0, 2, 1'b0, 2, 1, 0};
    vecs[5] = '{0, 0, 0, 1'b1, 2, 0, 1};
    vecs[6] = '{2, 1, 0, 1'b0, 3, 1, 1};
    vecs[7] = '{0, 0, 1, 1'b0, 2, 0, 1};

    do_reset();
    check("reset_thick", cfg_thick, 2);
    check("reset_show", cfg_show_cl, 1);
    check("reset_upd", cfg_upd, 0);
    check("reset_busy", busy, 0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      for (int k = 0; k < vecs[i].n_plus; k++) press(1, 0, 0);
      for (int k = 0; k < vecs[i].n_minus; k++) press(0, 1, 0);
      for (int k = 0; k < vecs[i].n_show; k++) press(0, 0, 1);
      if (vecs[i].simul) press(1, 1, 1);
      check($sformatf("v%0d_midframe_thick", i), cfg_thick, 2);
      check($sformatf("v%0d_busy_pending", i), busy, vecs[i].exp_upd);
      frame(u, e);
      check($sformatf("v%0d_upd", i), u, vecs[i].exp_upd);
      check($sformatf("v%0d_extra_upd", i), e, 0);
      check($sformatf("v%0d_thick", i), cfg_thick, vecs[i].exp_thick);
      check($sformatf("v%0d_show", i), cfg_show_cl, vecs[i].exp_show);
      check($sformatf("v%0d_busy_after", i), busy, 0);
    end

    // Short glitch never completes debounce.
    do_reset();
    plus_thick = 1'b0;
    repeat (3) tick();
    check("glitch_busy_mid", busy, 1);
    plus_thick = 1'b1;
    repeat (10) tick();
    check("glitch_busy_idle", busy, 0);
    frame(u, e);
    check("glitch_upd", u, 0);
    check("glitch_thick", cfg_thick, 2);

    // Saturation at max across frames.
    do_reset();
    repeat (8) press(1, 0, 0);
    frame(u, e);
    check("sat_thick_first", cfg_thick, 8);
    press(1, 0, 0);
    check("sat_busy", busy, 0);
    frame(u, e);
    check("sat_upd", u, 0);
    check("sat_thick", cfg_thick, 8);

    // Press event lands in the same cycle as frame_start.
    do_reset();
    plus_thick = 1'b0;
    repeat (6) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("coinc_thick_before", cfg_thick, 2);
    check("coinc_upd", cfg_upd, 1);
    tick();
    check("coinc_thick", cfg_thick, 3);
    check("coinc_upd_once", cfg_upd, 0);
    plus_thick = 1'b1;
    repeat (10) tick();

    // Reset during DEB_PRESS discards the press.
    do_reset();
    minus_thick = 1'b0;
    repeat (4) tick();
    check("rstdeb_busy_mid", busy, 1);
    rst = 1'b1;
    minus_thick = 1'b1;
    tick();
    check("rstdeb_busy_rst", busy, 0);
    rst = 1'b0;
    repeat (10) tick();
    check("rstdeb_busy_after", busy, 0);
    frame(u, e);
    check("rstdeb_upd", u, 0);
    check("rstdeb_thick", cfg_thick, 2);

    // Held through reset: short hold afterwards is not a press, a full one is.
    do_reset();
    minus_thick = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();
    minus_thick = 1'b1;
    repeat (10) tick();
    frame(u, e);
    check("held_short_upd", u, 0);
    check("held_short_thick", cfg_thick, 2);
    minus_thick = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    minus_thick = 1'b1;
    repeat (10) tick();
    frame(u, e);
    check("held_full_upd", u, 1);
    check("held_full_thick", cfg_thick, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_disp_cfg_ctrl.md
VGA_DISP_CFG_CTRL -- requirements
Module: vga_disp_cfg_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 500000, stable-level cycles required to accept a button change (20 ms at 25 MHz).
REQ-002 Parameter THICK_MIN, default 1, minimum wave half-thickness in lines.
REQ-003 Parameter THICK_MAX, default 8, maximum wave half-thickness in lines.
REQ-004 Parameter THICK_RST, default 2, reset half-thickness.
REQ-005 clk  input  1  pixel clock (25 MHz); single clock domain.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 show_cl  input  1  raw pushbutton, active-low, asynchronous to clk.
REQ-008 plus_thick  input  1  raw pushbutton, active-low, asynchronous to clk.
REQ-009 minus_thick  input  1  raw pushbutton, active-low, asynchronous to clk.
REQ-010 frame_start  input  1  one-cycle pulse from timing generator at start of vertical blank.
REQ-011 cfg_show_cl  output  1  committed centre-line enable.
REQ-012 cfg_thick  output  4  committed half-thickness, THICK_MIN..THICK_MAX.
REQ-013 cfg_upd  output  1  one-cycle pulse: committed config changed this cycle.
REQ-014 busy  output  1  high while any button is mid-debounce or a pending change awaits commit.

Function
REQ-015 Each button passes through a 2-flop synchroniser before any use.
REQ-016 Each button has its own FSM, states IDLE, DEB_PRESS, HELD, DEB_REL.
REQ-017 IDLE -> DEB_PRESS when synchronised level is 0; counter loads 0.
REQ-018 DEB_PRESS: level 0 for DEBOUNCE_CYC consecutive cycles -> HELD, emitting one-cycle press event; any 1 -> IDLE.
REQ-019 HELD -> DEB_REL when level is 1; DEB_REL -> IDLE after DEBOUNCE_CYC consecutive 1s, any 0 -> HELD.
REQ-020 Exactly one press event per accepted press; holding never auto-repeats.
REQ-021 Debounce counters are sized ceil(log2(DEBOUNCE_CYC+1)) bits and never wrap.
REQ-022 show_cl press toggles pending show-line bit.
REQ-023 plus_thick press increments pending thickness, saturating at THICK_MAX.
REQ-024 minus_thick press decrements pending thickness, saturating at THICK_MIN.
REQ-025 plus and minus press events in the same cycle: pending thickness unchanged.
REQ-026 Pending registers copy to cfg_show_cl/cfg_thick only in the cycle after frame_start; mid-frame outputs never change.
REQ-027 cfg_upd asserts in the commit cycle only if at least one committed value differs from its prior value.
REQ-028 Press event coinciding with frame_start: pending update applies first, and the commit one cycle later includes it.
REQ-029 Multiple presses within one frame accumulate; only the final pending value is committed.
REQ-030 busy = any FSM in DEB_PRESS or DEB_REL, or pending differs from committed.

Reset
REQ-031 rst asserted: all FSMs IDLE, counters 0, synchronisers 1, pending and committed show-line 1, pending and committed thickness THICK_RST, cfg_upd 0, busy 0.
REQ-032 rst asserted mid-debounce or with a pending change discards it; no press event and no cfg_upd follow deassertion.
REQ-033 Button held low through reset deassertion is accepted as a new press only after a full DEBOUNCE_CYC.

Structure
REQ-034 The shared package vga_pkg holds the button FSM state enumeration and the THICK_MIN/THICK_MAX/THICK_RST defaults.
REQ-035 One sub-module, btn_debounce (synchroniser, FSM, counter, press-event output), is instantiated three times.
REQ-036 The top level holds only the pending/committed registers, saturation logic and commit logic.

Verification
REQ-037 Bench runs with DEBOUNCE_CYC=4: plus_thick low for 6 cycles, then frame_start -> cfg_thick 2->3, cfg_upd one pulse one cycle after frame_start.
REQ-038 plus_thick glitches low for 3 cycles, then high -> no event, cfg_thick stays 2, no cfg_upd at next frame.
REQ-039 Eight plus presses in one frame -> cfg_thick 8 at commit; a further plus press and frame -> 8, no cfg_upd.
REQ-040 plus and minus pressed simultaneously plus show_cl press -> commit gives cfg_thick 2, cfg_show_cl 0, one cfg_upd.
REQ-041 show_cl pressed twice in one frame -> commit leaves cfg_show_cl 1, no cfg_upd, busy low after release debounce.
REQ-042 rst pulsed during DEB_PRESS of minus_thick -> after release, cfg_thick 2, no cfg_upd at next frame_start.
